// File: rtl/sram_1rw_masked_init.sv
// Single-port behavioural SRAM with per-lane write mask, valid/ready request
// side, pipelined read response that holds its last data, and an optional
// post-reset sweep that writes INIT_VALUE into every entry.
module sram_1rw_masked_init #(
    parameter int unsigned DEPTH        = 32,
    parameter int unsigned WIDTH        = 148,
    parameter int unsigned MASK_LANES   = 2,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned INIT_EN      = 1,
    parameter logic [WIDTH/MASK_LANES-1:0] INIT_VALUE = '0,
    localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [MASK_LANES-1:0] req_wmask,
    input  logic [WIDTH-1:0]      req_wdata,
    output logic                  resp_valid,
    output logic [WIDTH-1:0]      resp_rdata,
    output logic                  init_done
);

    localparam int unsigned LW = WIDTH / MASK_LANES;
    localparam logic [WIDTH-1:0]  INIT_WORD = {MASK_LANES{INIT_VALUE}};
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    // Reject geometries the array cannot implement
    if (WIDTH % MASK_LANES != 0) begin : g_err_lanes
        $error("MASK_LANES must divide WIDTH exactly");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_err_lat
        $error("READ_LATENCY must be within 1..3");
    end
    if (DEPTH < 2) begin : g_err_depth
        $error("DEPTH must be at least 2");
    end

    typedef enum logic {
        S_INIT  = 1'b0,
        S_READY = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_W-1:0]       cnt_q, cnt_d;
    logic                    init_we;
    logic                    in_range;
    logic                    wr_acc;
    logic                    rd_acc;
    logic [WIDTH-1:0]        rd_word;
    logic [WIDTH-1:0]        mem_q [DEPTH];
    logic [READ_LATENCY-1:0] vld_q;
    logic [WIDTH-1:0]        dat_q [READ_LATENCY];

    // Address range check; trivially true when DEPTH fills the address space
    if (DEPTH == (2 ** ADDR_W)) begin : g_full_range
        assign in_range = 1'b1;
    end else begin : g_part_range
        assign in_range = ({1'b0, req_addr} < (ADDR_W + 1)'(DEPTH));
    end

    assign wr_acc  = req_valid && req_ready && req_wen;
    assign rd_acc  = req_valid && req_ready && !req_wen;
    assign rd_word = in_range ? mem_q[req_addr] : '0;

    // FSM state and clear-sweep counter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: sweep one entry per cycle, leave INIT after the last entry
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        init_we = 1'b0;
        case (state_q)
            S_INIT: begin
                if (INIT_EN != 0) begin
                    init_we = 1'b1;
                    cnt_d   = cnt_q + ADDR_W'(1);
                    if (cnt_q == LAST_ADDR) begin
                        state_d = S_READY;
                        cnt_d   = '0;
                    end
                end else begin
                    state_d = S_READY;
                end
            end
            S_READY: begin
                state_d = S_READY;
            end
        endcase
    end

    // Ready and init_done come straight from the state flop
    assign req_ready = (state_q == S_READY);
    assign init_done = (state_q == S_READY);

    // Storage: clear sweep or masked request write; contents are never reset
    always_ff @(posedge clock) begin
        if (init_we) begin
            mem_q[cnt_q] <= INIT_WORD;
        end else if (wr_acc && in_range) begin
            for (int l = 0; l < MASK_LANES; l++) begin
                if (req_wmask[l]) begin
                    mem_q[req_addr][l*LW +: LW] <= req_wdata[l*LW +: LW];
                end
            end
        end
    end

    // Read pipeline; data stages load only behind a valid so the last one holds
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= rd_acc;
            if (rd_acc) begin
                dat_q[0] <= rd_word;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    assign resp_valid = vld_q[READ_LATENCY-1];
    assign resp_rdata = dat_q[READ_LATENCY-1];

endmodule
